pb_conditioner: RTL and testbench

- N-channel pushbutton front end that turns raw board buttons into clean, single-cycle events for downstream logic.
- Generalises the top-level sync + saturating-lockout scheme in width and debounce depth, and adds release events and auto-repeat.
- Sits between the board pins and application blocks such as counters and LED drivers. Runs entirely in the 50 MHz clock domain.

---
 rtl/pb_cond_pkg.sv | 24 ++
 rtl/pb_channel.sv | 127 ++++++++++++
 rtl/pb_conditioner.sv | 41 ++++
 tb/tb_pb_conditioner.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_cond_pkg.sv
// Shared types and helpers for the pushbutton conditioner: per-channel FSM states
// and the counter-width derivation.
package pb_cond_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOCK,
        HOLD,
        REPT,
        RLOCK
    } state_t;

    // Counter only ever reaches (terminal - 1), so clog2 of the largest terminal suffices.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pb_channel.sv
// One button channel: synchroniser, lockout/hold/repeat FSM and its shared counter.
// Input arrives already inverted so that 1 always means pressed.
module pb_channel
    import pb_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 3,
    parameter int unsigned LOCKOUT_CNT  = 15000000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic rep_en,
    output logic level,
    output logic press_evt,
    output logic release_evt,
    output logic repeat_evt
);

    localparam int unsigned CNT_W = cnt_width(LOCKOUT_CNT, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CNT - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_s;
    state_t                 state, next_state;
    logic [CNT_W-1:0]       cnt, next_cnt;
    logic                   level_nx, press_nx, release_nx, repeat_nx;

    assign lvl_s = sync_q[SYNC_STAGES-1];

    // State register; outputs are registered so every event is a clean single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            state       <= IDLE;
            cnt         <= '0;
            level       <= 1'b0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
            repeat_evt  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync_q      <= {sync_q[SYNC_STAGES-2:0], din};
            state       <= next_state;
            cnt         <= next_cnt;
            level       <= level_nx;
            press_evt   <= press_nx;
            release_evt <= release_nx;
            repeat_evt  <= repeat_nx;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch behind.
        next_state = state;
        next_cnt   = cnt + CNT_W'(1);
        unique case (state)
            IDLE: begin
                next_cnt = '0;
                if (lvl_s) next_state = LOCK;
            end
            LOCK: begin
                if (cnt == LOCK_LAST) begin
                    next_cnt   = '0;
                    next_state = lvl_s ? HOLD : RLOCK;
                end
            end
            HOLD: begin
                if (!lvl_s) begin
                    next_cnt   = '0;
                    next_state = RLOCK;
                end else if (!rep_en) begin
                    next_cnt = '0;
                end else if (cnt == DELAY_LAST) begin
                    next_cnt   = '0;
                    next_state = REPT;
                end
            end
            REPT: begin
                if (!lvl_s) begin
                    next_cnt   = '0;
                    next_state = RLOCK;
                end else if (!rep_en) begin
                    next_cnt   = '0;
                    next_state = HOLD;
                end else if (cnt == RATE_LAST) begin
                    next_cnt = '0;
                end
            end
            RLOCK: begin
                if (cnt == LOCK_LAST) begin
                    next_cnt   = '0;
                    next_state = IDLE;
                end
            end
            default: begin
                next_cnt   = '0;
                next_state = IDLE;
            end
        endcase
    end

    // Event decode: each pulse marks the transition taken on this edge.
    always_comb begin
        press_nx   = 1'b0;
        release_nx = 1'b0;
        repeat_nx  = 1'b0;
        level_nx   = (next_state == LOCK) || (next_state == HOLD) || (next_state == REPT);
        unique case (state)
            IDLE:    press_nx   = lvl_s;
            LOCK:    release_nx = (cnt == LOCK_LAST) && !lvl_s;
            HOLD: begin
                release_nx = !lvl_s;
                repeat_nx  = lvl_s && rep_en && (cnt == DELAY_LAST);
            end
            REPT: begin
                release_nx = !lvl_s;
                repeat_nx  = lvl_s && rep_en && (cnt == RATE_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pb_conditioner.sv
// N-channel pushbutton front end: applies the per-pin polarity mask and fans out
// one independent conditioning channel per button.
module pb_conditioner
    import pb_cond_pkg::*;
#(
    parameter int unsigned       N_CH         = 2,
    parameter int unsigned       SYNC_STAGES  = 3,
    parameter logic [N_CH-1:0]   INVERT_MASK  = {N_CH{1'b1}},
    parameter int unsigned       LOCKOUT_CNT  = 15000000,
    parameter int unsigned       REPEAT_DELAY = 25000000,
    parameter int unsigned       REPEAT_RATE  = 5000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] pb_raw,
    input  logic [N_CH-1:0] rep_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_evt,
    output logic [N_CH-1:0] release_evt,
    output logic [N_CH-1:0] repeat_evt
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pb_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .LOCKOUT_CNT (LOCKOUT_CNT),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .din        (pb_raw[i] ^ INVERT_MASK[i]),
            .rep_en     (rep_en[i]),
            .level      (level[i]),
            .press_evt  (press_evt[i]),
            .release_evt(release_evt[i]),
            .repeat_evt (repeat_evt[i])
        );
    end

endmodule

// File: tb/tb_pb_conditioner.sv
// Testbench for pb_conditioner: directed scenarios plus randomized pin activity,
// compared every cycle against a countdown-based behavioural model.
module tb_pb_conditioner;

    localparam int N_CH    = 2;
    localparam int SYNC    = 2;
    localparam int LOCKOUT = 8;
    localparam int DELAY   = 20;
    localparam int RATE    = 5;
    localparam logic [N_CH-1:0] INV = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N_CH-1:0] pb_raw = '1;
    logic [N_CH-1:0] rep_en = '0;
    logic [N_CH-1:0] level, press_evt, release_evt, repeat_evt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ev_press[N_CH], ev_release[N_CH], ev_repeat[N_CH];

    // Behavioural model: delayed view of the pin, a lockout countdown and a hold timer.
    logic [SYNC-1:0] m_pipe [N_CH];
    logic [N_CH-1:0] m_level = '0, m_press = '0, m_release = '0, m_repeat = '0;
    int m_lock [N_CH];
    int m_held [N_CH];
    bit m_rep  [N_CH];

    pb_conditioner #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC), .INVERT_MASK(INV),
        .LOCKOUT_CNT(LOCKOUT), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk), .reset(reset), .pb_raw(pb_raw), .rep_en(rep_en),
        .level(level), .press_evt(press_evt), .release_evt(release_evt), .repeat_evt(repeat_evt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            bit s;
            s = m_pipe[c][SYNC-1];
            m_press[c] = 1'b0; m_release[c] = 1'b0; m_repeat[c] = 1'b0;
            if (reset) begin
                m_pipe[c] = '0; m_level[c] = 1'b0;
                m_lock[c] = 0; m_held[c] = 0; m_rep[c] = 1'b0;
            end else begin
                if (m_lock[c] > 0) begin
                    m_lock[c]--;
                    if (m_lock[c] == 0 && m_level[c]) begin
                        if (!s) begin
                            m_release[c] = 1'b1; m_level[c] = 1'b0; m_lock[c] = LOCKOUT;
                        end else begin
                            m_held[c] = 0; m_rep[c] = 1'b0;
                        end
                    end
                end else if (!m_level[c]) begin
                    if (s) begin
                        m_press[c] = 1'b1; m_level[c] = 1'b1; m_lock[c] = LOCKOUT;
                    end
                end else if (!s) begin
                    m_release[c] = 1'b1; m_level[c] = 1'b0; m_lock[c] = LOCKOUT;
                end else if (!rep_en[c]) begin
                    m_held[c] = 0; m_rep[c] = 1'b0;
                end else begin
                    m_held[c]++;
                    if (m_held[c] == (m_rep[c] ? RATE : DELAY)) begin
                        m_repeat[c] = 1'b1; m_held[c] = 0; m_rep[c] = 1'b1;
                    end
                end
                m_pipe[c] = {m_pipe[c][SYNC-2:0], pb_raw[c] ^ INV[c]};
            end
        end
    end

    function automatic logic [4*N_CH-1:0] dut_vec();
        return {level, press_evt, release_evt, repeat_evt};
    endfunction

    function automatic logic [4*N_CH-1:0] model_vec();
        return {m_level, m_press, m_release, m_repeat};
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int c = 0; c < N_CH; c++) begin
            ev_press[c]   += (press_evt[c]   === 1'b1) ? 1 : 0;
            ev_release[c] += (release_evt[c] === 1'b1) ? 1 : 0;
            ev_repeat[c]  += (repeat_evt[c]  === 1'b1) ? 1 : 0;
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < N_CH; c++) begin
            ev_press[c] = 0; ev_release[c] = 0; ev_repeat[c] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; pb_raw = '1; rep_en = '0;
        repeat (2) step();
        reset = 1'b0;
        clear_counts();
    endtask

    task automatic test_reset();
        logic [4*N_CH-1:0] any_out;
        reset = 1'b1; pb_raw = '1; rep_en = 2'($urandom);
        step();
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++; $display("FAIL reset_first_edge: got %b want 0", dut_vec());
        end
        step();
        reset = 1'b0; rep_en = '0;
        any_out = '0;
        repeat (100) begin
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL idle_model cyc %0d: dut=%b model=%b", cyc, dut_vec(), model_vec());
            end
            any_out |= dut_vec();
        end
        n_checks++;
        if (any_out !== '0) begin
            n_fail++; $display("FAIL idle_quiet: outputs seen %b want 0", any_out);
        end
    endtask

    task automatic test_press_release();
        int t0, first;
        do_reset();
        t0 = cyc; first = -1;
        pb_raw[0] = 1'b0;
        repeat (15) begin
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL press_model cyc %0d: dut=%b model=%b", cyc, dut_vec(), model_vec());
            end
            if (press_evt[0] === 1'b1 && first < 0) first = cyc - t0;
        end
        n_checks++;
        if (first != SYNC + 1) begin
            n_fail++; $display("FAIL press_latency: got %0d want %0d", first, SYNC + 1);
        end
        n_checks++;
        if (ev_press[0] != 1 || ev_press[1] != 0 || level !== 2'b01) begin
            n_fail++; $display("FAIL press_once: presses %0d/%0d level %b want 1/0 01", ev_press[0], ev_press[1], level);
        end
        pb_raw[0] = 1'b1;
        repeat (25) begin
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL release_model cyc %0d: dut=%b model=%b", cyc, dut_vec(), model_vec());
            end
        end
        n_checks++;
        if (ev_release[0] != 1 || ev_press[0] != 1 || level[0] !== 1'b0) begin
            n_fail++; $display("FAIL release_once: rel %0d press %0d level %b want 1 1 0", ev_release[0], ev_press[0], level[0]);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        pb_raw[0] = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL bounce_model cyc %0d: dut=%b model=%b", cyc, dut_vec(), model_vec());
            end
            if (i == 1 || i == 5) pb_raw[0] = 1'b1;
            else if (i == 3 || i == 7) pb_raw[0] = 1'b0;
        end
        n_checks++;
        if (ev_press[0] != 1 || ev_release[0] != 0 || level[0] !== 1'b1) begin
            n_fail++; $display("FAIL bounce_fixed: press %0d rel %0d level %b want 1 0 1", ev_press[0], ev_release[0], level[0]);
        end
        pb_raw[0] = 1'b1;
        repeat (20) step();
        clear_counts();
        pb_raw[0] = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL rbounce_model cyc %0d: dut=%b model=%b", cyc, dut_vec(), model_vec());
            end
            pb_raw[0] = (i <= 6) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        n_checks++;
        if (ev_press[0] != 1 || ev_release[0] != 0) begin
            n_fail++; $display("FAIL bounce_random: press %0d rel %0d want 1 0", ev_press[0], ev_release[0]);
        end
        pb_raw[0] = 1'b1;
        repeat (20) step();
    endtask

    task automatic test_repeat();
        int press_at, rel_at, nrep;
        do_reset();
        rep_en[0] = 1'b1;
        press_at = -1; rel_at = -1; nrep = 0;
        pb_raw[0] = 1'b0;
        for (int i = 1; i <= 90; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL repeat_model cyc %0d: dut=%b model=%b", cyc, dut_vec(), model_vec());
            end
            if (press_evt[0] === 1'b1) press_at = cyc;
            if (repeat_evt[0] === 1'b1) begin
                n_checks++;
                if (rel_at >= 0 || cyc - press_at != LOCKOUT + DELAY + RATE * nrep) begin
                    n_fail++; $display("FAIL repeat_time #%0d: offset %0d want %0d", nrep, cyc - press_at, LOCKOUT + DELAY + RATE * nrep);
                end
                nrep++;
            end
            if (release_evt[0] === 1'b1) rel_at = cyc;
            if (i == 60) pb_raw[0] = 1'b1;
        end
        n_checks++;
        if (nrep != 7 || ev_release[0] != 1) begin
            n_fail++; $display("FAIL repeat_count: repeats %0d rel %0d want 7 1", nrep, ev_release[0]);
        end
        rep_en[0] = 1'b0;
    endtask

    task automatic test_rep_disable();
        int r, first;
        do_reset();
        pb_raw[0] = 1'b0;
        repeat (100) begin
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL norep_model cyc %0d: dut=%b model=%b", cyc, dut_vec(), model_vec());
            end
        end
        n_checks++;
        if (ev_repeat[0] != 0 || level[0] !== 1'b1) begin
            n_fail++; $display("FAIL norep_hold: repeats %0d level %b want 0 1", ev_repeat[0], level[0]);
        end
        rep_en[0] = 1'b1;
        r = cyc; first = -1;
        repeat (30) begin
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL enrep_model cyc %0d: dut=%b model=%b", cyc, dut_vec(), model_vec());
            end
            if (repeat_evt[0] === 1'b1 && first < 0) first = cyc - r;
        end
        n_checks++;
        if (first != DELAY) begin
            n_fail++; $display("FAIL enrep_latency: got %0d want %0d", first, DELAY);
        end
        rep_en[0] = 1'b0; pb_raw[0] = 1'b1;
        repeat (15) step();
    endtask

    task automatic test_both_and_reset();
        int first;
        do_reset();
        pb_raw = '0;
        first = -1;
        for (int i = 1; i <= 5; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL both_model cyc %0d: dut=%b model=%b", cyc, dut_vec(), model_vec());
            end
            if (press_evt === 2'b11 && first < 0) first = i;
        end
        n_checks++;
        if (first != SYNC + 1 || ev_press[0] != 1 || ev_press[1] != 1) begin
            n_fail++; $display("FAIL both_same_cycle: at %0d counts %0d/%0d want %0d 1/1", first, ev_press[0], ev_press[1], SYNC + 1);
        end
        reset = 1'b1;
        step();
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++; $display("FAIL lock_reset: got %b want 0", dut_vec());
        end
        step();
        reset = 1'b0;
        first = -1;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL rerelease_model cyc %0d: dut=%b model=%b", cyc, dut_vec(), model_vec());
            end
            if (press_evt === 2'b11 && first < 0) first = i;
        end
        n_checks++;
        if (first != SYNC + 1) begin
            n_fail++; $display("FAIL held_through_reset: at %0d want %0d", first, SYNC + 1);
        end
        pb_raw = '1;
        repeat (25) step();
    endtask

    task automatic test_random();
        int hold[N_CH];
        do_reset();
        for (int c = 0; c < N_CH; c++) hold[c] = 0;
        repeat (600) begin
            for (int c = 0; c < N_CH; c++) begin
                if (hold[c] == 0) begin
                    pb_raw[c] = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 45);
                end else begin
                    hold[c]--;
                end
                if ($urandom_range(0, 49) == 0) rep_en[c] = ~rep_en[c];
            end
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL random_model cyc %0d: dut=%b model=%b", cyc, dut_vec(), model_vec());
            end
            for (int c = 0; c < N_CH; c++) begin
                n_checks++;
                if (int'(press_evt[c]) + int'(release_evt[c]) + int'(repeat_evt[c]) > 1) begin
                    n_fail++; $display("FAIL one_event ch%0d cyc %0d: p%b r%b t%b want at most one", c, cyc, press_evt[c], release_evt[c], repeat_evt[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_repeat();
        test_rep_disable();
        test_both_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
